// File: rtl/iq_eth_packetizer.sv
// iq_eth_packetizer: packs 32-bit IQ samples into raw Ethernet frames for the MAC
// transmit stream. Two payload buffers ping-pong: one fills while the other is sent,
// so a frame is only started once its whole payload is already stored.
//
// Handshakes:
//   in_*    : a sample moves on a cycle where in_valid & in_ready are both high.
//   ff_tx_* : a word moves on a cycle where ff_tx_wren & ff_tx_rdy are both high; while
//             wren is high and rdy is low, data/sop/eop stay stable.
module iq_eth_packetizer #(
   parameter int SAMPLES_PER_PKT = 256,
   parameter int SEQ_W           = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic [47:0] dst_mac,
   input  logic [47:0] src_mac,
   input  logic [15:0] ethertype,
   input  logic [31:0] in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [31:0] ff_tx_data,
   output logic        ff_tx_sop,
   output logic        ff_tx_eop,
   output logic [1:0]  ff_tx_mod,
   output logic        ff_tx_err,
   output logic        ff_tx_crc_fwd,
   output logic        ff_tx_wren,
   input  logic        ff_tx_rdy,
   output logic [31:0] pkt_count,
   output logic        busy,
   output logic [2:0]  dbg_tx_state
);

   localparam int N  = SAMPLES_PER_PKT;
   localparam int AW = $clog2(2 * N);
   localparam int CW = $clog2(N);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      HDR0 = 3'd1,
      HDR1 = 3'd2,
      HDR2 = 3'd3,
      HDR3 = 3'd4,
      PAY  = 3'd5
   } tx_state_t;

   tx_state_t         state, state_d;
   logic [31:0]       mem [0:2*N-1];
   logic [1:0]        full;
   logic              fill_buf;
   logic [CW-1:0]     fill_idx;
   logic              tx_buf;
   logic [CW-1:0]     pay_idx;
   logic [SEQ_W-1:0]  seq;
   logic [47:0]       dst_q;
   logic [47:0]       src_q;
   logic [15:0]       type_q;
   logic              accept;
   logic              fill_last;
   logic              xfer;
   logic              eop_xfer;
   logic              frame_start;
   logic [AW-1:0]     wr_addr;
   logic [AW-1:0]     rd_addr;
   logic [31:0]       rd_data;

   assign in_ready    = enable & ~full[fill_buf];
   assign accept      = in_valid & in_ready;
   assign fill_last   = (fill_idx == CW'(N - 1));
   assign xfer        = ff_tx_wren & ff_tx_rdy;
   assign eop_xfer    = xfer & ff_tx_eop;
   assign frame_start = (state == IDLE) & full[tx_buf] & enable;

   assign wr_addr = fill_buf ? (AW'(N) + AW'(fill_idx)) : AW'(fill_idx);
   assign rd_addr = tx_buf   ? (AW'(N) + AW'(pay_idx))  : AW'(pay_idx);
   assign rd_data = mem[rd_addr];

   assign ff_tx_mod     = 2'b00;
   assign ff_tx_err     = 1'b0;
   assign ff_tx_crc_fwd = 1'b0;
   assign busy          = (state != IDLE) | (|full);
   assign dbg_tx_state  = state;

   // Payload storage; the buffer being sent is never a write target.
   always_ff @(posedge clk) begin
      if (accept) mem[wr_addr] <= in_data;
   end

   // Fill side: sample index, fill buffer select, and per-buffer full flags.
   // Fill completion and eop freeing always touch different buffers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fill_idx <= '0;
         fill_buf <= 1'b0;
         full     <= 2'b00;
      end else begin
         if (accept) begin
            if (fill_last) begin
               fill_idx <= '0;
               fill_buf <= ~fill_buf;
            end else begin
               fill_idx <= fill_idx + CW'(1);
            end
         end
         full[0] <= (full[0] & ~(eop_xfer & ~tx_buf)) | (accept & fill_last & ~fill_buf);
         full[1] <= (full[1] & ~(eop_xfer &  tx_buf)) | (accept & fill_last &  fill_buf);
      end
   end

   // TX state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_d;
   end

   // TX next state and MAC-side outputs; a state only advances on a transfer.
   always_comb begin
      state_d    = state;
      ff_tx_wren = 1'b0;
      ff_tx_sop  = 1'b0;
      ff_tx_eop  = 1'b0;
      ff_tx_data = 32'h0;
      case (state)
         IDLE: begin
            if (frame_start) state_d = HDR0;
         end
         HDR0: begin
            ff_tx_wren = 1'b1;
            ff_tx_sop  = 1'b1;
            ff_tx_data = dst_q[47:16];
            if (ff_tx_rdy) state_d = HDR1;
         end
         HDR1: begin
            ff_tx_wren = 1'b1;
            ff_tx_data = {dst_q[15:0], src_q[47:32]};
            if (ff_tx_rdy) state_d = HDR2;
         end
         HDR2: begin
            ff_tx_wren = 1'b1;
            ff_tx_data = src_q[31:0];
            if (ff_tx_rdy) state_d = HDR3;
         end
         HDR3: begin
            ff_tx_wren = 1'b1;
            ff_tx_data = {type_q, seq};
            if (ff_tx_rdy) state_d = PAY;
         end
         PAY: begin
            ff_tx_wren = 1'b1;
            ff_tx_data = rd_data;
            ff_tx_eop  = (pay_idx == CW'(N - 1));
            if (ff_tx_rdy && ff_tx_eop) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // TX datapath: header latch, payload index, buffer turn, sequence and frame count.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dst_q     <= '0;
         src_q     <= '0;
         type_q    <= '0;
         pay_idx   <= '0;
         tx_buf    <= 1'b0;
         seq       <= '0;
         pkt_count <= '0;
      end else begin
         if (frame_start) begin
            dst_q  <= dst_mac;
            src_q  <= src_mac;
            type_q <= ethertype;
         end
         if (xfer && state == PAY) begin
            if (ff_tx_eop) pay_idx <= '0;
            else           pay_idx <= pay_idx + CW'(1);
         end
         if (eop_xfer) begin
            tx_buf    <= ~tx_buf;
            seq       <= seq + SEQ_W'(1);
            pkt_count <= pkt_count + 32'd1;
         end
      end
   end

endmodule

// File: tb/tb_iq_eth_packetizer.sv
// Bench for iq_eth_packetizer: random sample streams and MAC back-pressure, with every
// transferred word checked against frames assembled from the accepted-sample queue.
module tb_iq_eth_packetizer;

   localparam int N     = 11;
   localparam int WORDS = N + 4;

   // ---------------- clock / reset ----------------
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        enable = 1'b0;
   logic [47:0] dst = 48'h0;
   logic [47:0] src = 48'h0;
   logic [15:0] etype = 16'h0;
   logic [31:0] in_data = 32'h0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] ff_tx_data;
   logic        ff_tx_sop, ff_tx_eop, ff_tx_err, ff_tx_crc_fwd, ff_tx_wren;
   logic [1:0]  ff_tx_mod;
   logic        ff_tx_rdy = 1'b0;
   logic [31:0] pkt_count;
   logic        busy;
   logic [2:0]  dbg_tx_state;

   always #5 clk = ~clk;

   iq_eth_packetizer #(.SAMPLES_PER_PKT(N), .SEQ_W(16)) dut (
      .clk(clk), .reset(reset), .enable(enable),
      .dst_mac(dst), .src_mac(src), .ethertype(etype),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .ff_tx_data(ff_tx_data), .ff_tx_sop(ff_tx_sop), .ff_tx_eop(ff_tx_eop),
      .ff_tx_mod(ff_tx_mod), .ff_tx_err(ff_tx_err), .ff_tx_crc_fwd(ff_tx_crc_fwd),
      .ff_tx_wren(ff_tx_wren), .ff_tx_rdy(ff_tx_rdy),
      .pkt_count(pkt_count), .busy(busy), .dbg_tx_state(dbg_tx_state)
   );

   // ---------------- scoreboard ----------------
   int          n_vec = 0;
   int          n_err = 0;
   logic [31:0] samp_q [$];   // accepted samples in acceptance order
   logic [31:0] exp_q  [$];   // remaining words of the frame on the wire
   int          w_idx  = 0;
   logic [15:0] m_seq  = 16'h0;
   int          m_pkts = 0;
   logic        hold_v = 1'b0;
   logic [31:0] hold_d;
   logic        hold_s, hold_e;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Monitor: record accepted samples, check every transferred word, check stall stability.
   always @(negedge clk) begin
      if (reset) begin
         if (in_valid && in_ready) samp_q.push_back(in_data);
         if (hold_v) begin
            check("stall_wren", 32'(ff_tx_wren), 32'd1);
            check("stall_data", ff_tx_data, hold_d);
            check("stall_sop", 32'(ff_tx_sop), 32'(hold_s));
            check("stall_eop", 32'(ff_tx_eop), 32'(hold_e));
         end
         hold_v = 1'b0;
         if (ff_tx_wren) begin
            if (ff_tx_rdy) begin
               if (w_idx == 0) begin
                  exp_q.delete();
                  exp_q.push_back(dst[47:16]);
                  exp_q.push_back({dst[15:0], src[47:32]});
                  exp_q.push_back(src[31:0]);
                  exp_q.push_back({etype, m_seq});
                  if (samp_q.size() < N) check("frame_underfed", 32'(samp_q.size()), 32'(N));
                  for (int i = 0; i < N && samp_q.size() > 0; i++) exp_q.push_back(samp_q.pop_front());
               end
               if (exp_q.size() == 0) check("extra_word", 32'd1, 32'd0);
               else                   check("word", ff_tx_data, exp_q.pop_front());
               check("sop", 32'(ff_tx_sop), 32'(w_idx == 0));
               check("eop", 32'(ff_tx_eop), 32'(w_idx == WORDS - 1));
               if (w_idx == WORDS - 1) begin
                  w_idx = 0;
                  m_seq = m_seq + 16'd1;
                  m_pkts++;
               end else begin
                  w_idx++;
               end
            end else begin
               hold_v = 1'b1;
               hold_d = ff_tx_data;
               hold_s = ff_tx_sop;
               hold_e = ff_tx_eop;
            end
         end
      end else begin
         hold_v = 1'b0;
      end
   end

   // ---------------- driver tasks ----------------
   // rdy modes: 0 always 1, 1 toggle, 2 random, 3 held 0
   task automatic drive_rdy(input int mode);
      case (mode)
         0: ff_tx_rdy = 1'b1;
         1: ff_tx_rdy = ~ff_tx_rdy;
         2: ff_tx_rdy = 1'($urandom_range(0, 1));
         default: ff_tx_rdy = 1'b0;
      endcase
   endtask

   task automatic tick(input int mode);
      @(posedge clk);
      #1;
      drive_rdy(mode);
   endtask

   task automatic send(input int count, input int mode, input bit gaps, input bit ramp);
      int got = 0;
      int budget = 0;
      logic acc;
      while (got < count && budget < 3000) begin
         in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
         in_data  = ramp ? 32'(got) : $urandom;
         @(negedge clk);
         acc = in_valid & in_ready;
         tick(mode);
         if (acc) got++;
         budget++;
      end
      in_valid = 1'b0;
      if (got < count) check("send_timeout", 32'(got), 32'(count));
   endtask

   task automatic drain(input int target, input int mode);
      int b = 0;
      while ((m_pkts < target || busy) && b < 3000) begin
         tick(mode);
         b++;
      end
      check("drain_done", 32'(b < 3000), 32'd1);
      check("model_pkts", 32'(m_pkts), 32'(target));
      check("pkt_count", pkt_count, 32'(target));
      check("busy_idle", 32'(busy), 32'd0);
   endtask

   task automatic rand_hdr();
      dst[47:32] = 16'($urandom);
      dst[31:0]  = $urandom;
      src[47:32] = 16'($urandom);
      src[31:0]  = $urandom;
      etype      = 16'($urandom);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
      check({tag, "_wren"}, 32'(ff_tx_wren), 32'd0);
      check({tag, "_sop"}, 32'(ff_tx_sop), 32'd0);
      check({tag, "_eop"}, 32'(ff_tx_eop), 32'd0);
      check({tag, "_data"}, ff_tx_data, 32'd0);
      check({tag, "_pkt_count"}, pkt_count, 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_consts"}, {28'd0, ff_tx_mod, ff_tx_err, ff_tx_crc_fwd}, 32'd0);
   endtask

   // ---------------- test sequence ----------------
   initial begin
      int lat;
      int acc_cnt;
      logic acc;

      repeat (3) @(posedge clk);
      #1;
      check_reset_values("rst");
      reset = 1'b1;
      tick(0);
      check_reset_values("post_rst");

      // Frame with fixed header and ramp payload; also first-frame latency.
      dst = 48'h0011_2233_4455;
      src = 48'h6677_8899_AABB;
      etype = 16'h88B5;
      enable = 1'b1;
      send(N, 0, 1'b0, 1'b1);
      lat = 0;
      while (!ff_tx_wren && lat < 4) begin
         tick(0);
         lat++;
      end
      check("latency_le2", 32'(lat <= 2), 32'd1);
      drain(1, 0);

      // Toggling ready, random payload with gaps.
      rand_hdr();
      send(N, 1, 1'b1, 1'b0);
      drain(2, 1);

      // Continuous input, three frames back to back.
      send(3 * N, 0, 1'b0, 1'b0);
      drain(5, 0);

      // Long MAC stall during the first frame: second buffer fills, then input blocks.
      rand_hdr();
      send(N, 3, 1'b0, 1'b0);
      acc_cnt = 0;
      for (int c = 0; c < 100; c++) begin
         in_valid = 1'b1;
         in_data  = $urandom;
         @(negedge clk);
         acc = in_valid & in_ready;
         tick(3);
         if (acc) acc_cnt++;
      end
      check("stall_accepts", 32'(acc_cnt), 32'(N));
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_pkts", pkt_count, 32'd5);
      in_valid = 1'b0;
      send(N, 0, 1'b0, 1'b0);
      drain(8, 2);

      // Partial fill retained across an enable drop.
      send(5, 0, 1'b0, 1'b0);
      enable = 1'b0;
      in_valid = 1'b1;
      repeat (5) begin
         tick(0);
         check("dis_in_ready", 32'(in_ready), 32'd0);
         check("dis_busy", 32'(busy), 32'd0);
      end
      in_valid = 1'b0;
      enable = 1'b1;
      send(N - 5, 0, 1'b1, 1'b0);
      drain(9, 0);

      // Sequence wrap 0xFFFF -> 0x0000.
      force dut.seq = 16'hFFFF;
      m_seq = 16'hFFFF;
      tick(0);
      release dut.seq;
      send(2 * N, 2, 1'b1, 1'b0);
      drain(11, 2);
      check("seq_after_wrap", 32'(m_seq), 32'h1);

      // Enable drop mid-fill, then reset with a frame in flight.
      rand_hdr();
      send(N, 3, 1'b0, 1'b0);
      repeat (3) tick(0);
      drive_rdy(3);
      send(5, 3, 1'b0, 1'b0);
      enable = 1'b0;
      tick(3);
      check("pre_rst_in_ready", 32'(in_ready), 32'd0);
      check("pre_rst_wren", 32'(ff_tx_wren), 32'd1);
      reset = 1'b0;
      #2;
      check_reset_values("mid_rst");
      samp_q.delete();
      exp_q.delete();
      w_idx  = 0;
      m_seq  = 16'h0;
      m_pkts = 0;
      repeat (2) tick(0);
      reset = 1'b1;
      enable = 1'b1;
      tick(0);
      send(N, 0, 1'b0, 1'b0);
      drain(1, 0);
      check("seq_after_rst", 32'(m_seq), 32'h1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // Global watchdog.
   initial begin
      #900000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
